masked_ram_sync: RTL and testbench

Parametrised single-clock RAM with per-bit write mask, registered read port, write/read collision control and a hardware clear sequencer. It replaces the combinational-read masked RAM in the synth datapath (voice state, envelope and oscillator tables), where block-RAM inference requires a registered read and voice state must be zeroed deterministically after reset or on a patch change. The clear walks the whole array in hardware, so no initial-block initialisation is required.

---
 rtl/masked_ram_sync.sv | 131 +++++++++++++
 tb/tb_masked_ram_sync.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_ram_sync.sv
// Single-clock RAM with per-bit write mask, registered read port,
// collision bypass option and a hardware clear sweep.
//
// Ports:
//   clk      : sole clock, all state changes on the rising edge
//   rst      : synchronous active-high reset, starts a clear sweep
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   wr_mask  : per-bit mask, 1 takes wr_data bit, 0 keeps stored bit
//   rd_en    : read strobe
//   rd_addr  : read address
//   rd_data  : registered read data, held until the next accepted read
//   rd_valid : one-cycle pulse when rd_data was updated
//   clear    : request a clear sweep (honoured only when idle)
//   busy     : clear sweep in progress, port accesses are dropped
module masked_ram_sync #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  parameter bit                    BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  clear,
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nx;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic [ADDR_WIDTH-1:0]   clr_addr_nx;
  logic                    clr_last;
  logic                    wr_go;
  logic                    rd_go;
  logic                    hit;
  logic [DATA_WIDTH-1:0]   old_wr;
  logic [DATA_WIDTH-1:0]   merged;
  logic [DATA_WIDTH-1:0]   rd_word;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign clr_last = (clr_addr == {ADDR_WIDTH{1'b1}});
  assign busy     = (state == S_CLEAR);

  // Merge of the masked write against the current stored word.
  assign old_wr = mem[wr_addr];
  assign merged = (wr_data & wr_mask) | (old_wr & ~wr_mask);

  // A same-address write either forwards its merged word or
  // lets the read see the pre-write contents.
  assign hit     = wr_go && (wr_addr == rd_addr);
  assign rd_word = (BYPASS && hit) ? merged : mem[rd_addr];

  always_comb begin
    state_nx    = state;
    clr_addr_nx = clr_addr;
    wr_go       = 1'b0;
    rd_go       = 1'b0;
    unique case (state)
      S_CLEAR: begin
        clr_addr_nx = clr_addr + 1'b1;
        if (clr_last) begin
          state_nx = S_IDLE;
        end
      end
      S_IDLE: begin
        if (clear) begin
          state_nx    = S_CLEAR;
          clr_addr_nx = '0;
        end else begin
          wr_go = wr_en;
          rd_go = rd_en;
        end
      end
      default: begin
        state_nx    = S_CLEAR;
        clr_addr_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nx;
      clr_addr <= clr_addr_nx;
    end
  end

  // Storage carries no reset; the sweep initialises it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR) begin
        mem[clr_addr] <= INIT_VALUE;
      end else if (wr_go) begin
        mem[wr_addr] <= merged;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_go;
      if (rd_go) begin
        rd_data <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_masked_ram_sync.sv
// Self-checking bench for masked_ram_sync: two instances (forwarding
// and old-data collision modes) share stimulus against an array model.
module tb_masked_ram_sync;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;
  localparam logic [DW-1:0] INIT = 8'hA5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] wr_mask = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          clear = 1'b0;

  logic [DW-1:0] rd_data1, rd_data0;
  logic          rd_valid1, rd_valid0;
  logic          busy1, busy0;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  masked_ram_sync #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .INIT_VALUE(INIT), .BYPASS(1'b1)
  ) u_byp (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1),
    .clear(clear), .busy(busy1)
  );

  masked_ram_sync #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .INIT_VALUE(INIT), .BYPASS(1'b0)
  ) u_old (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data0), .rd_valid(rd_valid0),
    .clear(clear), .busy(busy0)
  );

  function automatic logic [DW-1:0] mrg(
    input logic [DW-1:0] o,
    input logic [DW-1:0] d,
    input logic [DW-1:0] m
  );
    return (d & m) | (o & ~m);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0;
    rd_en = 1'b0;
    clear = 1'b0;
  endtask

  task automatic ref_fill_init();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = INIT;
  endtask

  task automatic do_write(
    input logic [AW-1:0] a,
    input logic [DW-1:0] d,
    input logic [DW-1:0] m
  );
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_mask = m;
    ref_mem[a] = mrg(ref_mem[a], d, m);
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) begin
      logic [DW-1:0] d;
      d = DW'($urandom_range(1, 255));
      if (d == INIT) d = 8'h5A;
      do_write(AW'(i), d, 8'hFF);
    end
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    checks++;
    if (rd_data1 !== 8'h00 || rd_data0 !== 8'h00) begin
      failures++;
      $display("FAIL reset_rd_data: got %h/%h want 00", rd_data1, rd_data0);
    end
    checks++;
    if (rd_valid1 !== 1'b0 || rd_valid0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_rd_valid: got %b/%b want 0", rd_valid1, rd_valid0);
    end
    checks++;
    if (busy1 !== 1'b1 || busy0 !== 1'b1) begin
      failures++;
      $display("FAIL reset_busy: got %b/%b want 1", busy1, busy0);
    end
    rst = 1'b0;
    n = 0;
    while (busy1 === 1'b1 && n < 100) begin
      n++;
      cyc();
    end
    checks++;
    if (n != DEPTH || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy_len: got %0d want %0d", n, DEPTH);
    end
    ref_fill_init();
  endtask

  task automatic test_readback();
    int bad;
    bad = 0;
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1'b1;
      rd_addr = AW'(a);
      cyc();
      checks++;
      if (rd_valid1 !== 1'b1 || rd_valid0 !== 1'b1 ||
          rd_data1 !== ref_mem[a] || rd_data0 !== ref_mem[a]) begin
        failures++;
        bad++;
        $display("FAIL readback[%0d]: got %h/%h v=%b/%b want %h",
                 a, rd_data1, rd_data0, rd_valid1, rd_valid0, ref_mem[a]);
      end
    end
    rd_en = 1'b0;
    cyc();
    checks++;
    if (rd_valid1 !== 1'b0 || rd_valid0 !== 1'b0) begin
      failures++;
      $display("FAIL readback_valid_drop: got %b/%b want 0",
               rd_valid1, rd_valid0);
    end
  endtask

  task automatic test_mask();
    do_write(4'd3, 8'hFF, 8'hFF);
    do_write(4'd3, 8'h00, 8'h0F);
    rd_en = 1'b1;
    rd_addr = 4'd3;
    cyc();
    rd_en = 1'b0;
    checks++;
    if (rd_data1 !== 8'hF0 || rd_data0 !== 8'hF0) begin
      failures++;
      $display("FAIL mask_merge: got %h/%h want f0", rd_data1, rd_data0);
    end
    do_write(4'd3, 8'h0F, 8'h00);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    checks++;
    if (rd_data1 !== 8'hF0 || rd_data0 !== 8'hF0) begin
      failures++;
      $display("FAIL mask_zero: got %h/%h want f0", rd_data1, rd_data0);
    end
    for (int i = 0; i < 40; i++) begin
      do_write(AW'($urandom), DW'($urandom), DW'($urandom));
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] old_w, new_w;
    do_write(4'd7, 8'h11, 8'hFF);
    old_w = ref_mem[7];
    new_w = mrg(old_w, 8'h2C, 8'hFF);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h2C; wr_mask = 8'hFF;
    rd_en = 1'b1; rd_addr = 4'd7;
    ref_mem[7] = new_w;
    cyc();
    idle_inputs();
    checks++;
    if (rd_data1 !== new_w || rd_valid1 !== 1'b1) begin
      failures++;
      $display("FAIL collide_bypass: got %h want %h", rd_data1, new_w);
    end
    checks++;
    if (rd_data0 !== old_w || rd_valid0 !== 1'b1) begin
      failures++;
      $display("FAIL collide_old: got %h want %h", rd_data0, old_w);
    end
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    checks++;
    if (rd_data1 !== 8'h2C || rd_data0 !== 8'h2C) begin
      failures++;
      $display("FAIL collide_after: got %h/%h want 2c", rd_data1, rd_data0);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] last1, last0, e1, e0, d, m;
    logic we, re;
    logic [AW-1:0] wa, ra;
    last1 = rd_data1;
    last0 = rd_data0;
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom);
      re = 1'($urandom);
      wa = AW'($urandom);
      ra = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom);
      d = DW'($urandom);
      m = DW'($urandom);
      wr_en = we; wr_addr = wa; wr_data = d; wr_mask = m;
      rd_en = re; rd_addr = ra;
      e1 = last1;
      e0 = last0;
      if (re) begin
        e0 = ref_mem[ra];
        e1 = (we && wa == ra) ? mrg(ref_mem[wa], d, m) : ref_mem[ra];
      end
      if (we) ref_mem[wa] = mrg(ref_mem[wa], d, m);
      cyc();
      checks++;
      if (rd_valid1 !== re || rd_valid0 !== re ||
          rd_data1 !== e1 || rd_data0 !== e0) begin
        failures++;
        $display("FAIL random[%0d]: got %h/%h v=%b/%b want %h/%h v=%b",
                 i, rd_data1, rd_data0, rd_valid1, rd_valid0, e1, e0, re);
      end
      last1 = e1;
      last0 = e0;
    end
    idle_inputs();
  endtask

  task automatic test_busy_ignore();
    int n, seen;
    idle_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h3C; wr_mask = 8'hFF;
    rd_en = 1'b1; rd_addr = 4'd5;
    n = 0;
    seen = 0;
    while (busy1 === 1'b1 && n < 100) begin
      if (rd_valid1 !== 1'b0 || rd_valid0 !== 1'b0) seen++;
      n++;
      cyc();
    end
    idle_inputs();
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL busy_rd_valid: got %0d pulses want 0", seen);
    end
    checks++;
    if (n != DEPTH) begin
      failures++;
      $display("FAIL busy_len_ports: got %0d want %0d", n, DEPTH);
    end
    ref_fill_init();
  endtask

  task automatic test_clear_with_write();
    int n;
    fill_random();
    clear = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h77; wr_mask = 8'hFF;
    rd_en = 1'b1; rd_addr = 4'd2;
    cyc();
    idle_inputs();
    checks++;
    if (rd_valid1 !== 1'b0 || rd_valid0 !== 1'b0) begin
      failures++;
      $display("FAIL clear_req_read: got %b/%b want 0", rd_valid1, rd_valid0);
    end
    n = 0;
    while (busy1 === 1'b1 && n < 100) begin
      n++;
      cyc();
    end
    checks++;
    if (n != DEPTH) begin
      failures++;
      $display("FAIL clear_busy_len: got %0d want %0d", n, DEPTH);
    end
    ref_fill_init();
  endtask

  task automatic test_rst_mid_clear();
    int n;
    fill_random();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    repeat (9) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n = 0;
    while (busy1 === 1'b1 && n < 100) begin
      n++;
      cyc();
    end
    checks++;
    if (n != DEPTH) begin
      failures++;
      $display("FAIL rst_mid_clear_len: got %0d want %0d", n, DEPTH);
    end
    ref_fill_init();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_readback();
    test_mask();
    test_readback();
    test_collision();
    test_random();
    test_readback();
    test_busy_ignore();
    test_readback();
    test_clear_with_write();
    test_readback();
    test_rst_mid_clear();
    test_readback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
